// File: rtl/updown_counter_seq_if.sv
// ============================================================================
// updown_counter_seq_if : command/status bundle of the up/down counter sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

interface updown_counter_seq_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_len;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             wrapped;

  modport master (
    output cmd_valid, cmd_dir, cmd_start, cmd_len, pause, abort,
    input  cmd_ready, busy, done, result, wrapped
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_start, cmd_len, pause, abort,
    output cmd_ready, busy, done, result, wrapped
  );
endinterface

`default_nettype wire

// File: rtl/updown_counter_seq.sv
// ============================================================================
// updown_counter_seq : runs one load/step job per command on an external counter
// Revision 1.0
// ============================================================================
`default_nettype none

module updown_counter_seq #(
  parameter int WIDTH    = 8,
  parameter int STEP_GAP = 0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  updown_counter_seq_if.slave   cmd,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_data,
  output logic                  cnt_en,
  output logic                  cnt_m,
  input  wire logic [WIDTH-1:0] cnt_count
);

  localparam bit       HAS_GAP  = (STEP_GAP > 0);
  localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(STEP_GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [3:0]       gap_q, gap_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wrapped_q, wrapped_d;
  logic             step_wraps;

  // Value seen before the step is the one that rolls over on this step.
  assign step_wraps = dir_q ? (cnt_count == '0) : (cnt_count == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      start_q     <= '0;
      remaining_q <= '0;
      gap_q       <= 4'd0;
      wrap_q      <= 1'b0;
      result_q    <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      start_q     <= start_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      wrap_q      <= wrap_d;
      result_q    <= result_d;
      wrapped_q   <= wrapped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    start_d     = start_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    wrap_d      = wrap_q;
    result_d    = result_q;
    wrapped_d   = wrapped_q;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          dir_d       = cmd.cmd_dir;
          start_d     = cmd.cmd_start;
          remaining_d = cmd.cmd_len;
          gap_d       = 4'd0;
          wrap_d      = 1'b0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (cmd.abort) begin
          state_d = S_IDLE;
        end else if (remaining_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (cmd.abort) begin
          state_d = S_IDLE;
        end else if (!cmd.pause) begin
          remaining_d = remaining_q - WIDTH'(1);
          if (step_wraps) begin
            wrap_d = 1'b1;
          end
          if (remaining_q == WIDTH'(1)) begin
            state_d = S_DONE;
          end else if (HAS_GAP) begin
            gap_d   = 4'd0;
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (cmd.abort) begin
          state_d = S_IDLE;
        end else if (!cmd.pause) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = 4'd0;
            state_d = S_RUN;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
      end

      S_DONE: begin
        result_d  = cnt_count;
        wrapped_d = wrap_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_load      = (state_q == S_LOAD);
  assign cnt_data      = start_q;
  assign cnt_en        = (state_q == S_RUN) && !cmd.pause;
  assign cnt_m         = (state_q != S_IDLE) && dir_q;

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign cmd.busy      = (state_q != S_IDLE);
  assign cmd.done      = (state_q == S_DONE);
  assign cmd.result    = result_q;
  assign cmd.wrapped   = wrapped_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_seq.sv
// ============================================================================
// tb_updown_counter_seq : directed jobs on two sequencers (gap 0 and gap 2)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_updown_counter_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_start = 8'd0;
  logic [7:0] cmd_len = 8'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  always #5 clk = ~clk;

  updown_counter_seq_if #(.WIDTH(8)) bus0 ();
  updown_counter_seq_if #(.WIDTH(8)) bus2 ();

  assign bus0.cmd_valid = cmd_valid & ~sel;
  assign bus0.pause     = pause & ~sel;
  assign bus0.abort     = abort & ~sel;
  assign bus0.cmd_dir   = cmd_dir;
  assign bus0.cmd_start = cmd_start;
  assign bus0.cmd_len   = cmd_len;
  assign bus2.cmd_valid = cmd_valid & sel;
  assign bus2.pause     = pause & sel;
  assign bus2.abort     = abort & sel;
  assign bus2.cmd_dir   = cmd_dir;
  assign bus2.cmd_start = cmd_start;
  assign bus2.cmd_len   = cmd_len;

  logic       load0, en0, m0, load2, en2, m2;
  logic [7:0] data0, data2;
  logic [7:0] cnt0 = 8'd0;
  logic [7:0] cnt2 = 8'd0;

  updown_counter_seq #(.WIDTH(8), .STEP_GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(bus0),
    .cnt_load(load0), .cnt_data(data0), .cnt_en(en0), .cnt_m(m0), .cnt_count(cnt0)
  );

  updown_counter_seq #(.WIDTH(8), .STEP_GAP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cmd(bus2),
    .cnt_load(load2), .cnt_data(data2), .cnt_en(en2), .cnt_m(m2), .cnt_count(cnt2)
  );

  // Behavioural counters; deliberately not tied to rst_n.
  always @(posedge clk) begin
    if (load0) cnt0 <= data0;
    else if (en0) cnt0 <= m0 ? cnt0 - 8'd1 : cnt0 + 8'd1;
    if (load2) cnt2 <= data2;
    else if (en2) cnt2 <= m2 ? cnt2 - 8'd1 : cnt2 + 8'd1;
  end

  wire       m_ready  = sel ? bus2.cmd_ready : bus0.cmd_ready;
  wire       m_busy   = sel ? bus2.busy      : bus0.busy;
  wire       m_done   = sel ? bus2.done      : bus0.done;
  wire [7:0] m_result = sel ? bus2.result    : bus0.result;
  wire       m_wrap   = sel ? bus2.wrapped   : bus0.wrapped;
  wire       m_load   = sel ? load2 : load0;
  wire       m_en     = sel ? en2   : en0;
  wire       m_m      = sel ? m2    : m0;
  wire [7:0] m_data   = sel ? data2 : data0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] res;
    logic       wrap;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  bit   pend0 = 1'b0;
  bit   pend2 = 1'b0;

  // Result/wrapped register on the DONE edge, so they are compared one cycle after done.
  always @(negedge clk) begin
    exp_t e;
    if (pend0) begin
      if (q0.size() == 0) chk("unexpected_done0", 1, 0);
      else begin
        e = q0.pop_front();
        chk("result0", int'(bus0.result), int'(e.res));
        chk("wrapped0", int'(bus0.wrapped), int'(e.wrap));
      end
    end
    if (pend2) begin
      if (q2.size() == 0) chk("unexpected_done2", 1, 0);
      else begin
        e = q2.pop_front();
        chk("result2", int'(bus2.result), int'(e.res));
        chk("wrapped2", int'(bus2.wrapped), int'(e.wrap));
      end
    end
    pend0 = rst_n && bus0.done;
    pend2 = rst_n && bus2.done;
  end

  int load_k, load_n, load_data, en_n, en_first, en_last, min_gap;
  int done_k, done_n, ready_k, mbad;

  task automatic run_job(input bit s, input bit dir, input logic [7:0] start,
                         input logic [7:0] len, input int pause_at, input int pause_n,
                         input int abort_at, input int poke_at, input bit exp_done,
                         input logic [7:0] exp_res, input bit exp_wrap);
    int  k;
    int  last_en;
    bit  fin;
    if (exp_done) begin
      if (s) q2.push_back('{exp_res, exp_wrap});
      else   q0.push_back('{exp_res, exp_wrap});
    end
    @(posedge clk); #1;
    sel = s; cmd_dir = dir; cmd_start = start; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    chk("ready_at_accept", int'(m_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    load_k = 0; load_n = 0; load_data = -1; en_n = 0; en_first = 0; en_last = 0;
    min_gap = 999; done_k = 0; done_n = 0; ready_k = 0; mbad = 0; last_en = 0;
    k = 1; fin = 1'b0;
    while (!fin) begin
      pause = (pause_n > 0) && (k >= pause_at) && (k < pause_at + pause_n);
      abort = (k == abort_at);
      if (k == poke_at) begin
        cmd_valid = 1'b1; cmd_start = 8'hEE; cmd_len = 8'd1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (m_load) begin load_n++; load_k = k; load_data = int'(m_data); end
      if (m_en) begin
        if (en_n == 0) en_first = k;
        else if (k - last_en - 1 < min_gap) min_gap = k - last_en - 1;
        en_last = k; last_en = k; en_n++;
        if (m_m != dir) mbad++;
      end
      if (m_done) begin done_n++; if (done_k == 0) done_k = k; end
      if (m_ready) begin
        ready_k = k; fin = 1'b1;
      end else if (k >= 400) begin
        chk("job_timeout", k, 0); fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    pause = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ready", int'(bus0.cmd_ready), 1);
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_load_en", int'({load0, en0, m0}), 0);
    chk("rst_data", int'(data0), 0);
    chk("rst_result", int'(bus0.result), 0);
    chk("rst_done_wrap", int'({bus0.done, bus0.wrapped}), 0);
    #20 rst_n = 1'b1;

    // Up-count, with a stray command offered mid-job.
    run_job(0, 0, 8'd10, 8'd5, 0, 0, 0, 3, 1, 8'd15, 0);
    chk("t1_load_k", load_k, 1);
    chk("t1_load_data", load_data, 10);
    chk("t1_en_first", en_first, 2);
    chk("t1_en_last", en_last, 6);
    chk("t1_en_n", en_n, 5);
    chk("t1_done_k", done_k, 7);
    chk("t1_done_n", done_n, 1);
    chk("t1_ready_k", ready_k, 8);
    chk("t1_data_hold", int'(m_data), 10);
    chk("t1_m", mbad, 0);

    // Down-count through zero.
    run_job(0, 1, 8'd2, 8'd4, 0, 0, 0, 0, 1, 8'd254, 1);
    chk("t2_en_n", en_n, 4);
    chk("t2_done_k", done_k, 6);
    chk("t2_m", mbad, 0);

    // Load-only job.
    run_job(0, 0, 8'h5A, 8'd0, 0, 0, 0, 0, 1, 8'h5A, 0);
    chk("t4_load_n", load_n, 1);
    chk("t4_en_n", en_n, 0);
    chk("t4_done_k", done_k, 2);
    chk("t4_ready_k", ready_k, 3);

    // Abort sampled in the fourth RUN cycle.
    run_job(0, 0, 8'd100, 8'd20, 0, 0, 5, 0, 0, 8'd0, 0);
    chk("ab_en_n", en_n, 4);
    chk("ab_done_n", done_n, 0);
    chk("ab_ready_k", ready_k, 6);
    chk("ab_count", int'(cnt0), 104);
    chk("ab_result_kept", int'(m_result), 'h5A);
    chk("ab_wrap_kept", int'(m_wrap), 0);

    // Up-count through all-ones.
    run_job(0, 0, 8'd250, 8'd7, 0, 0, 0, 0, 1, 8'd1, 1);
    chk("up_wrap_en_n", en_n, 7);

    // Maximum length.
    run_job(0, 0, 8'd0, 8'd255, 0, 0, 0, 0, 1, 8'd255, 0);
    chk("max_en_n", en_n, 255);
    chk("max_done_k", done_k, 257);

    // Gap of 2 with a 3-cycle pause on the second RUN.
    run_job(1, 0, 8'd0, 8'd3, 5, 3, 0, 0, 1, 8'd3, 0);
    chk("gp_en_n", en_n, 3);
    chk("gp_en_first", en_first, 2);
    chk("gp_en_last", en_last, 11);
    chk("gp_min_gap", min_gap, 2);
    chk("gp_done_k", done_k, 12);
    chk("gp_run_cycles", done_k - 2, 10);

    // Pause and abort together in GAP after a wrapping step.
    run_job(1, 1, 8'd0, 8'd5, 3, 2, 4, 0, 0, 8'd0, 0);
    chk("pa_en_n", en_n, 1);
    chk("pa_ready_k", ready_k, 5);
    chk("pa_done_n", done_n, 0);
    chk("pa_result_kept", int'(m_result), 3);
    chk("pa_wrap_kept", int'(m_wrap), 0);

    // Asynchronous reset in the middle of a job.
    @(posedge clk); #1;
    sel = 1'b0; cmd_dir = 1'b0; cmd_start = 8'd0; cmd_len = 8'd50; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("mid_busy", int'(bus0.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(bus0.busy), 0);
    chk("ar_en_load_m", int'({en0, load0, m0}), 0);
    chk("ar_data", int'(data0), 0);
    chk("ar_result", int'(bus0.result), 0);
    chk("ar_done_wrap", int'({bus0.done, bus0.wrapped}), 0);
    cmd_start = 8'd77; cmd_len = 8'd1; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ar_ignore_busy", int'(bus0.busy), 0);
    chk("ar_ignore_load", int'(load0), 0);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b1;

    run_job(0, 1, 8'd5, 8'd3, 0, 0, 0, 0, 1, 8'd2, 0);
    chk("post_rst_done_k", done_k, 5);
    chk("post_rst_en_n", en_n, 3);

    repeat (3) @(negedge clk);
    chk("sb_drain0", q0.size(), 0);
    chk("sb_drain2", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
